accelerator_temporal_link_update: RTL and testbench

Streaming fixed-point engine for the DNC temporal link matrix update L(t)[g;j] = (1 − w[g] − w[j])·L(t−1)[g;j] + w[g]·p(t−1)[j], with L[g;g] forced to 0. It sits in the DNC memory unit between the write-weighting and precedence-weighting producers and the link-matrix store. It buffers one w and one p vector of runtime length N ≤ MAX_N, then streams N×N link elements in row-major order through a 2-stage multiply/add pipeline. An init mode generates L(1) directly from w and p without reading L(t−1).

---
 rtl/accelerator_temporal_link_update.sv | 253 +++++++++++++++++++++++++
 tb/tb_accelerator_temporal_link_update.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_temporal_link_update.sv
// Temporal link matrix update engine for the DNC memory unit.
// Buffers one write-weighting vector w and one precedence vector p of runtime
// length N, then streams the N x N link matrix in row-major order:
//   L(t)[g;j] = (1 - w[g] - w[j]) * L(t-1)[g;j] + w[g] * p[j], with L[g;g] = 0.
// Init mode treats L(t-1) as zero and issues one element per cycle on its own.
// The two-stage pipeline does the multiplies in stage 1 and add/saturate in stage 2.
module accelerator_temporal_link_update #(
  parameter int DATA_SIZE  = 32,
  parameter int FRAC_SIZE  = 16,
  parameter int MAX_N      = 16,
  parameter int INDEX_SIZE = (MAX_N > 1) ? $clog2(MAX_N) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  MODE,
  input  logic [INDEX_SIZE:0]   SIZE_N_IN,
  input  logic                  W_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]  W_IN,
  input  logic                  P_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]  P_IN,
  input  logic                  L_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]  L_IN,
  output logic                  L_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]  L_OUT,
  output logic [INDEX_SIZE-1:0] L_OUT_G,
  output logic [INDEX_SIZE-1:0] L_OUT_J,
  output logic                  L_OUT_LAST,
  output logic                  BUSY,
  output logic                  READY,
  output logic                  ERROR
);

  localparam int PROD1_W = 2 * DATA_SIZE + 2;
  localparam int PROD2_W = 2 * DATA_SIZE;
  localparam int SUM_W   = PROD1_W + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD_W  = 3'd1;
  localparam logic [2:0] LOAD_P  = 3'd2;
  localparam logic [2:0] COMPUTE = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;

  localparam logic [INDEX_SIZE:0]        MAX_N_V = (INDEX_SIZE + 1)'(MAX_N);
  localparam logic [INDEX_SIZE-1:0]      IDX_ONE = INDEX_SIZE'(1);
  localparam logic signed [DATA_SIZE+1:0] ONE    = (DATA_SIZE + 2)'(1) << FRAC_SIZE;
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W - DATA_SIZE + 1){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W - DATA_SIZE + 1){1'b1}}, {(DATA_SIZE - 1){1'b0}}};

  logic [2:0]                  r_state;
  logic                        r_mode;
  logic [INDEX_SIZE-1:0]       r_lastIdx;
  logic [INDEX_SIZE-1:0]       r_loadCnt;
  logic [INDEX_SIZE-1:0]       r_g;
  logic [INDEX_SIZE-1:0]       r_j;
  logic                        r_ready;
  logic                        r_error;
  logic signed [DATA_SIZE-1:0] r_wBuf [MAX_N];
  logic signed [DATA_SIZE-1:0] r_pBuf [MAX_N];

  logic                        r_s1Valid;
  logic                        r_s1Last;
  logic                        r_s1Diag;
  logic [INDEX_SIZE-1:0]       r_s1G;
  logic [INDEX_SIZE-1:0]       r_s1J;
  logic signed [PROD1_W-1:0]   r_s1T1;
  logic signed [PROD2_W-1:0]   r_s1T2;

  logic                        r_outEn;
  logic                        r_outLast;
  logic [INDEX_SIZE-1:0]       r_outG;
  logic [INDEX_SIZE-1:0]       r_outJ;
  logic [DATA_SIZE-1:0]        r_outData;

  logic                        w_sizeValid;
  logic                        w_startSeen;
  logic                        w_accept;
  logic                        w_issue;
  logic                        w_rowEnd;
  logic signed [DATA_SIZE-1:0] w_wg;
  logic signed [DATA_SIZE-1:0] w_wj;
  logic signed [DATA_SIZE-1:0] w_pj;
  logic signed [DATA_SIZE-1:0] w_lVal;
  logic signed [DATA_SIZE+1:0] w_coeff;
  logic signed [PROD1_W-1:0]   w_coeffExt;
  logic signed [PROD1_W-1:0]   w_lExt;
  logic signed [PROD1_W-1:0]   w_prod1;
  logic signed [PROD2_W-1:0]   w_wgExt;
  logic signed [PROD2_W-1:0]   w_pjExt;
  logic signed [PROD2_W-1:0]   w_prod2;
  logic signed [SUM_W-1:0]     w_sum;
  logic [DATA_SIZE-1:0]        w_satData;

  // START is only honoured in IDLE once the READY pulse of the previous frame is over.
  assign w_sizeValid = (SIZE_N_IN != '0) && (SIZE_N_IN <= MAX_N_V);
  assign w_startSeen = START && (r_state == IDLE) && !r_ready;
  assign w_accept    = w_startSeen && w_sizeValid;
  assign w_issue     = (r_state == COMPUTE) && (r_mode || L_IN_ENABLE);
  assign w_rowEnd    = (r_j == r_lastIdx);

  // Frame sequencing: load w, load p, walk (g,j) row-major, wait for the pipeline to empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_mode    <= 1'b0;
      r_lastIdx <= '0;
      r_loadCnt <= '0;
      r_g       <= '0;
      r_j       <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_error <= w_startSeen && !w_sizeValid;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mode    <= MODE;
            r_lastIdx <= SIZE_N_IN[INDEX_SIZE-1:0] - IDX_ONE;
            r_loadCnt <= '0;
            r_g       <= '0;
            r_j       <= '0;
            r_state   <= LOAD_W;
          end
        end
        LOAD_W: begin
          if (W_IN_ENABLE) begin
            if (r_loadCnt == r_lastIdx) begin
              r_loadCnt <= '0;
              r_state   <= LOAD_P;
            end else begin
              r_loadCnt <= r_loadCnt + IDX_ONE;
            end
          end
        end
        LOAD_P: begin
          if (P_IN_ENABLE) begin
            if (r_loadCnt == r_lastIdx) begin
              r_loadCnt <= '0;
              r_state   <= COMPUTE;
            end else begin
              r_loadCnt <= r_loadCnt + IDX_ONE;
            end
          end
        end
        COMPUTE: begin
          if (w_issue) begin
            if (w_rowEnd) begin
              r_j <= '0;
              if (r_g == r_lastIdx) begin
                r_g     <= '0;
                r_state <= DRAIN;
              end else begin
                r_g <= r_g + IDX_ONE;
              end
            end else begin
              r_j <= r_j + IDX_ONE;
            end
          end
        end
        DRAIN: begin
          if (r_outEn && r_outLast) begin
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Vector buffers carry no reset; they are always rewritten before the next compute.
  always_ff @(posedge CLK) begin
    if ((r_state == LOAD_W) && W_IN_ENABLE) r_wBuf[r_loadCnt] <= W_IN;
    if ((r_state == LOAD_P) && P_IN_ENABLE) r_pBuf[r_loadCnt] <= P_IN;
  end

  // Products are formed at full width so the shifted terms never wrap before saturation.
  assign w_wg       = r_wBuf[r_g];
  assign w_wj       = r_wBuf[r_j];
  assign w_pj       = r_pBuf[r_j];
  assign w_lVal     = r_mode ? '0 : L_IN;
  assign w_coeff    = ONE - {{2{w_wg[DATA_SIZE-1]}}, w_wg} - {{2{w_wj[DATA_SIZE-1]}}, w_wj};
  assign w_coeffExt = {{DATA_SIZE{w_coeff[DATA_SIZE+1]}}, w_coeff};
  assign w_lExt     = {{(DATA_SIZE + 2){w_lVal[DATA_SIZE-1]}}, w_lVal};
  assign w_prod1    = w_coeffExt * w_lExt;
  assign w_wgExt    = {{DATA_SIZE{w_wg[DATA_SIZE-1]}}, w_wg};
  assign w_pjExt    = {{DATA_SIZE{w_pj[DATA_SIZE-1]}}, w_pj};
  assign w_prod2    = w_wgExt * w_pjExt;

  // Stage 1 captures both scaled products with the element's coordinates.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s1Valid <= 1'b0;
      r_s1Last  <= 1'b0;
      r_s1Diag  <= 1'b0;
      r_s1G     <= '0;
      r_s1J     <= '0;
      r_s1T1    <= '0;
      r_s1T2    <= '0;
    end else begin
      r_s1Valid <= w_issue;
      if (w_issue) begin
        r_s1Last <= w_rowEnd && (r_g == r_lastIdx);
        r_s1Diag <= (r_g == r_j);
        r_s1G    <= r_g;
        r_s1J    <= r_j;
        r_s1T1   <= w_prod1 >>> FRAC_SIZE;
        r_s1T2   <= w_prod2 >>> FRAC_SIZE;
      end
    end
  end

  // Sum the two terms and clamp into the signed data range.
  assign w_sum = {r_s1T1[PROD1_W-1], r_s1T1} + {{3{r_s1T2[PROD2_W-1]}}, r_s1T2};

  always_comb begin
    w_satData = w_sum[DATA_SIZE-1:0];
    if (w_sum > SAT_MAX) w_satData = SAT_MAX[DATA_SIZE-1:0];
    else if (w_sum < SAT_MIN) w_satData = SAT_MIN[DATA_SIZE-1:0];
  end

  // Stage 2 registers the output element; diagonal entries are forced to zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_outEn   <= 1'b0;
      r_outLast <= 1'b0;
      r_outG    <= '0;
      r_outJ    <= '0;
      r_outData <= '0;
    end else begin
      r_outEn   <= r_s1Valid;
      r_outLast <= r_s1Valid && r_s1Last;
      if (r_s1Valid) begin
        r_outG    <= r_s1G;
        r_outJ    <= r_s1J;
        r_outData <= r_s1Diag ? '0 : w_satData;
      end
    end
  end

  assign L_OUT_ENABLE = r_outEn;
  assign L_OUT        = r_outData;
  assign L_OUT_G      = r_outG;
  assign L_OUT_J      = r_outJ;
  assign L_OUT_LAST   = r_outLast;
  assign BUSY         = (r_state != IDLE) || r_ready;
  assign READY        = r_ready;
  assign ERROR        = r_error;

endmodule

// File: tb/tb_accelerator_temporal_link_update.sv
// Bench for the temporal link update engine: directed frames from the test plan
// plus randomized frames, every output cycle compared with a queue of expected
// elements computed from the link-update formula with wide integer arithmetic.
module tb_accelerator_temporal_link_update;

  localparam int DW = 32;
  localparam int MN = 16;
  localparam int IW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          MODE;
  logic [IW:0]   SIZE_N_IN;
  logic          W_IN_ENABLE;
  logic [DW-1:0] W_IN;
  logic          P_IN_ENABLE;
  logic [DW-1:0] P_IN;
  logic          L_IN_ENABLE;
  logic [DW-1:0] L_IN;
  logic          L_OUT_ENABLE;
  logic [DW-1:0] L_OUT;
  logic [IW-1:0] L_OUT_G;
  logic [IW-1:0] L_OUT_J;
  logic          L_OUT_LAST;
  logic          BUSY;
  logic          READY;
  logic          ERROR;

  accelerator_temporal_link_update dut (
    .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .SIZE_N_IN(SIZE_N_IN),
    .W_IN_ENABLE(W_IN_ENABLE), .W_IN(W_IN),
    .P_IN_ENABLE(P_IN_ENABLE), .P_IN(P_IN),
    .L_IN_ENABLE(L_IN_ENABLE), .L_IN(L_IN),
    .L_OUT_ENABLE(L_OUT_ENABLE), .L_OUT(L_OUT), .L_OUT_G(L_OUT_G), .L_OUT_J(L_OUT_J),
    .L_OUT_LAST(L_OUT_LAST), .BUSY(BUSY), .READY(READY), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic [31:0] val;
    int          g;
    int          j;
    bit          last;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   readyDue = -10;
  int   errDue = -10;
  int   mw [MN];
  int   mp [MN];
  exp_t q [$];

  // Reference element from the link-update formula, evaluated on 128-bit integers.
  function automatic logic [31:0] refElem(input int g, input int j, input logic signed [31:0] lv);
    logic signed [127:0] c, t1, t2, s, hi, lo;
    if (g == j) return 32'h0;
    c  = 65536;
    c  = c - mw[g] - mw[j];
    t1 = (c * lv) >>> 16;
    t2 = mw[g];
    t2 = (t2 * mp[j]) >>> 16;
    s  = t1 + t2;
    hi = 128'sd2147483647;
    lo = -hi - 1;
    if (s > hi) return 32'h7FFFFFFF;
    if (s < lo) return 32'h80000000;
    return s[31:0];
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      checkVal("out_enable", L_OUT_ENABLE, 1);
      checkVal("out_data", L_OUT, e.val);
      checkVal("out_g", L_OUT_G, e.g);
      checkVal("out_j", L_OUT_J, e.j);
      checkVal("out_last", L_OUT_LAST, e.last);
    end else begin
      checkVal("out_enable_idle", L_OUT_ENABLE, 0);
    end
    checkVal("ready", READY, cyc == readyDue);
    checkVal("error", ERROR, cyc == errDue);
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
    checkOutput();
  endtask

  task automatic applyStimulus();
    START       = 1'b0;
    W_IN_ENABLE = 1'b0;
    P_IN_ENABLE = 1'b0;
    L_IN_ENABLE = 1'b0;
    W_IN        = $urandom;
    P_IN        = $urandom;
    L_IN        = $urandom;
  endtask

  task automatic pushElem(input int g, input int j, input int n, input logic [31:0] lv);
    exp_t e;
    e.due  = cyc + 2;
    e.val  = refElem(g, j, lv);
    e.g    = g;
    e.j    = j;
    e.last = (g == n - 1) && (j == n - 1);
    q.push_back(e);
    if (e.last) readyDue = e.due + 1;
  endtask

  task automatic randomVectors(input int n);
    for (int k = 0; k < n; k++) begin
      mw[k] = int'($urandom_range(0, 131072)) - 65536;
      mp[k] = int'($urandom_range(0, 131072)) - 65536;
    end
  endtask

  // One frame: START, load w, load p, stream elements, drain to READY.
  task automatic runFrame(input bit mode, input int n, input int gap, input bit stray,
                          input bit lFixed, input logic [31:0] lConst, input int abortAfter);
    logic [31:0] lv;
    applyStimulus();
    START = 1'b1;
    MODE = mode;
    SIZE_N_IN = (IW + 1)'(n);
    tick();
    applyStimulus();
    checkVal("busy_after_start", BUSY, 1);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
        applyStimulus();
      end
      W_IN_ENABLE = 1'b1;
      W_IN = mw[k];
      if (stray) begin
        P_IN_ENABLE = 1'b1;
        START = 1'b1;
        SIZE_N_IN = '0;
      end
      tick();
      applyStimulus();
    end
    for (int k = 0; k < n; k++) begin
      P_IN_ENABLE = 1'b1;
      P_IN = mp[k];
      if (stray) W_IN_ENABLE = 1'b1;
      tick();
      applyStimulus();
    end
    for (int e = 0; e < n * n; e++) begin
      if (e == abortAfter) begin
        #1 RST = 1'b1;
        #1;
        checkVal("rst_l_out", L_OUT, 0);
        checkVal("rst_g", L_OUT_G, 0);
        checkVal("rst_j", L_OUT_J, 0);
        checkVal("rst_enable", L_OUT_ENABLE, 0);
        checkVal("rst_last", L_OUT_LAST, 0);
        checkVal("rst_busy", BUSY, 0);
        checkVal("rst_ready", READY, 0);
        q.delete();
        readyDue = -10;
        #1 RST = 1'b0;
        return;
      end
      if (mode) begin
        L_IN_ENABLE = 1'($urandom_range(0, 1));
        pushElem(e / n, e % n, n, 32'h0);
      end else begin
        for (int s = 1; s < gap; s++) begin
          tick();
          applyStimulus();
        end
        lv = lFixed ? lConst : 32'($urandom);
        L_IN_ENABLE = 1'b1;
        L_IN = lv;
        pushElem(e / n, e % n, n, lv);
      end
      tick();
      applyStimulus();
    end
    for (int t = 0; t < 10 && cyc < readyDue; t++) tick();
    checkVal("busy_in_ready", BUSY, 1);
    tick();
    checkVal("busy_after_ready", BUSY, 0);
    checkVal("queue_empty", q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST = 1'b1;
    MODE = 1'b0;
    SIZE_N_IN = '0;
    applyStimulus();
    repeat (3) tick();
    checkVal("reset_l_out", L_OUT, 0);
    checkVal("reset_g", L_OUT_G, 0);
    checkVal("reset_j", L_OUT_J, 0);
    checkVal("reset_last", L_OUT_LAST, 0);
    checkVal("reset_busy", BUSY, 0);
    RST = 1'b0;
    tick();

    $display("[TB] update mode N=2");
    mw[0] = 32'h8000; mw[1] = 32'h4000;
    mp[0] = 32'h4000; mp[1] = 32'h8000;
    runFrame(1'b0, 2, 0, 1'b0, 1'b1, 32'h10000, -1);

    $display("[TB] init mode N=2");
    runFrame(1'b1, 2, 0, 1'b0, 1'b0, 32'h0, -1);

    $display("[TB] saturation N=2");
    mw[0] = 32'hFFFE0000; mw[1] = 32'hFFFE0000;
    mp[0] = 0; mp[1] = 0;
    runFrame(1'b0, 2, 0, 1'b0, 1'b1, 32'h7FFF0000, -1);

    $display("[TB] invalid sizes");
    applyStimulus();
    START = 1'b1;
    SIZE_N_IN = '0;
    errDue = cyc + 1;
    tick();
    applyStimulus();
    checkVal("busy_err0", BUSY, 0);
    tick();
    START = 1'b1;
    SIZE_N_IN = (IW + 1)'(MN + 1);
    errDue = cyc + 1;
    tick();
    applyStimulus();
    checkVal("busy_err17", BUSY, 0);
    tick();

    $display("[TB] full size frame");
    randomVectors(MN);
    runFrame(1'b0, MN, 0, 1'b0, 1'b0, 32'h0, -1);

    $display("[TB] gapped L_IN with stray strobes");
    randomVectors(4);
    runFrame(1'b0, 4, 3, 1'b1, 1'b0, 32'h0, -1);

    $display("[TB] random init frame");
    randomVectors(5);
    runFrame(1'b1, 5, 0, 1'b0, 1'b0, 32'h0, -1);

    $display("[TB] reset during compute");
    randomVectors(4);
    runFrame(1'b0, 4, 0, 1'b0, 1'b0, 32'h0, 3);
    repeat (4) tick();
    randomVectors(3);
    runFrame(1'b0, 3, 0, 1'b0, 1'b0, 32'h0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
